// File: rtl/sha_core_arbiter.sv
// Round-robin share of one sha_256 core. Grant and start go high 1 cycle after a request is sampled;
// the done pulse comes 1 cycle after core valid. Requesters wait by holding i_req until their o_done.
module sha_core_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MSG_W       = 24,
    parameter int HASH_SIZE   = 256,
    parameter int TIMEOUT_CYC = 100
) (
    input  logic                     usr_clk,
    input  logic                     usr_reset_n,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ*MSG_W-1:0] i_msg,
    output logic [NUM_REQ-1:0]       o_gnt,
    output logic [NUM_REQ-1:0]       o_done,
    output logic                     o_err,
    output logic [HASH_SIZE-1:0]     o_hash,
    output logic                     o_busy,
    output logic                     o_core_start,
    output logic [MSG_W-1:0]         o_core_msg,
    input  logic                     i_core_valid,
    input  logic [HASH_SIZE-1:0]     i_core_hash
);

    localparam int                 PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0]     NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0]   LAST_IDX  = PTR_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);
    localparam logic [7:0]         WD_LAST   = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [PTR_W-1:0]     r_rr_ptr;
    logic [PTR_W-1:0]     r_gidx;
    logic [7:0]           r_wdog;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_done;
    logic                 r_err;
    logic [HASH_SIZE-1:0] r_hash;
    logic                 r_busy;
    logic                 r_core_start;
    logic [MSG_W-1:0]     r_core_msg;

    state_t               w_state;
    logic [PTR_W-1:0]     w_rr_ptr;
    logic [PTR_W-1:0]     w_gidx;
    logic [7:0]           w_wdog;
    logic [NUM_REQ-1:0]   w_gnt;
    logic [NUM_REQ-1:0]   w_done;
    logic                 w_err;
    logic [HASH_SIZE-1:0] w_hash;
    logic                 w_busy;
    logic                 w_core_start;
    logic [MSG_W-1:0]     w_core_msg;

    logic [NUM_REQ-1:0]   w_req_rot;
    logic [PTR_W-1:0]     w_off;
    logic [PTR_W:0]       w_sum;
    logic [PTR_W-1:0]     w_win;
    logic                 w_any;
    logic [PTR_W-1:0]     w_gidx_inc;

    // Rotate requests so bit 0 is rr_ptr; the lowest set bit is the winner's offset.
    always_comb begin
        w_req_rot = NUM_REQ'({i_req, i_req} >> r_rr_ptr);
        w_any     = |i_req;
        w_off     = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_req_rot[j]) begin
                w_off = PTR_W'(j);
            end
        end
        w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
        w_win = (w_sum >= NUM_REQ_W) ? PTR_W'(w_sum - NUM_REQ_W) : PTR_W'(w_sum);
        w_gidx_inc = (r_gidx == LAST_IDX) ? '0 : r_gidx + PTR_W'(1);
    end

    always_comb begin
        w_state      = r_state;
        w_rr_ptr     = r_rr_ptr;
        w_gidx       = r_gidx;
        w_wdog       = r_wdog;
        w_gnt        = r_gnt;
        w_done       = '0;
        w_err        = 1'b0;
        w_hash       = r_hash;
        w_busy       = r_busy;
        w_core_start = r_core_start;
        w_core_msg   = r_core_msg;

        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state      = S_BUSY;
                    w_gnt        = ONE_HOT0 << w_win;
                    w_gidx       = w_win;
                    w_core_msg   = i_msg[w_win*MSG_W +: MSG_W];
                    w_core_start = 1'b1;
                    w_wdog       = '0;
                    w_busy       = 1'b1;
                end
            end
            S_BUSY: begin
                w_wdog = r_wdog + 8'd1;
                // A valid arriving on the last watchdog cycle still counts as success.
                if (i_core_valid || (r_wdog == WD_LAST)) begin
                    w_state      = S_DONE;
                    w_done       = ONE_HOT0 << r_gidx;
                    w_err        = ~i_core_valid;
                    w_hash       = i_core_valid ? i_core_hash : '0;
                    w_gnt        = '0;
                    w_core_start = 1'b0;
                    w_rr_ptr     = w_gidx_inc;
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge usr_clk) begin
        if (!usr_reset_n) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_gidx       <= '0;
            r_wdog       <= '0;
            r_gnt        <= '0;
            r_done       <= '0;
            r_err        <= 1'b0;
            r_hash       <= '0;
            r_busy       <= 1'b0;
            r_core_start <= 1'b0;
            r_core_msg   <= '0;
        end else begin
            r_state      <= w_state;
            r_rr_ptr     <= w_rr_ptr;
            r_gidx       <= w_gidx;
            r_wdog       <= w_wdog;
            r_gnt        <= w_gnt;
            r_done       <= w_done;
            r_err        <= w_err;
            r_hash       <= w_hash;
            r_busy       <= w_busy;
            r_core_start <= w_core_start;
            r_core_msg   <= w_core_msg;
        end
    end

    assign o_gnt        = r_gnt;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_hash       = r_hash;
    assign o_busy       = r_busy;
    assign o_core_start = r_core_start;
    assign o_core_msg   = r_core_msg;

endmodule

// File: tb/tb_sha_core_arbiter.sv
// Directed bench for sha_core_arbiter with a latency-programmable sha_256 core stand-in.
module tb_sha_core_arbiter;

    localparam int NR = 4;
    localparam int MW = 24;
    localparam int HW = 256;
    localparam int TO = 100;
    localparam logic [255:0] ABC_HASH =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [23:0] M0 = 24'hA0A0A0;
    localparam logic [23:0] M1 = 24'hB1B1B1;
    localparam logic [23:0] M2 = 24'h616263;
    localparam logic [23:0] M3 = 24'hD3D3D3;

    logic             usr_clk = 1'b0;
    logic             usr_reset_n;
    logic [NR-1:0]    i_req;
    logic [NR*MW-1:0] i_msg;
    logic [NR-1:0]    o_gnt;
    logic [NR-1:0]    o_done;
    logic             o_err;
    logic [HW-1:0]    o_hash;
    logic             o_busy;
    logic             o_core_start;
    logic [MW-1:0]    o_core_msg;
    logic             i_core_valid;
    logic [HW-1:0]    i_core_hash;

    int n_checks = 0;
    int n_errors = 0;
    int core_lat = 0;
    int core_cnt = 0;
    int n;
    logic [NR-1:0] exp_oh;

    sha_core_arbiter #(
        .NUM_REQ(NR), .MSG_W(MW), .HASH_SIZE(HW), .TIMEOUT_CYC(TO)
    ) dut (
        .usr_clk(usr_clk), .usr_reset_n(usr_reset_n),
        .i_req(i_req), .i_msg(i_msg),
        .o_gnt(o_gnt), .o_done(o_done), .o_err(o_err), .o_hash(o_hash),
        .o_busy(o_busy), .o_core_start(o_core_start), .o_core_msg(o_core_msg),
        .i_core_valid(i_core_valid), .i_core_hash(i_core_hash)
    );

    always #5 usr_clk = ~usr_clk;

    function automatic logic [255:0] hash_of(input logic [23:0] msg);
        return ABC_HASH ^ {232'd0, msg ^ 24'h616263};
    endfunction

    // Core stand-in: valid for one cycle after core_lat cycles of start; core_lat 0 means never.
    always @(negedge usr_clk) begin
        if (o_core_start && core_lat > 0) begin
            core_cnt     = core_cnt + 1;
            i_core_valid = (core_cnt == core_lat);
        end else begin
            core_cnt     = 0;
            i_core_valid = 1'b0;
        end
        i_core_hash = hash_of(o_core_msg);
    end

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge usr_clk);
    endtask

    task automatic wait_gnt(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (o_gnt == '0 && cnt < 300);
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (o_done == '0 && cnt < 300);
    endtask

    initial begin
        usr_reset_n  = 1'b0;
        i_req        = '0;
        i_msg        = {M3, M2, M1, M0};
        i_core_valid = 1'b0;
        i_core_hash  = '0;
        core_lat     = 66;
        repeat (3) tick();
        chk("rst_gnt", o_gnt, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        chk("rst_hash", o_hash, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_start", o_core_start, 0);
        chk("rst_msg", o_core_msg, 0);
        usr_reset_n = 1'b1;

        // Single request from requester 2 carrying "abc".
        i_req = 4'b0100;
        wait_gnt(n);
        chk("one_gnt_lat", n, 1);
        chk("one_gnt", o_gnt, 4'b0100);
        chk("one_msg", o_core_msg, M2);
        chk("one_start", o_core_start, 1);
        chk("one_busy", o_busy, 1);
        wait_done(n);
        chk("one_done_lat", n, 66);
        chk("one_done", o_done, 4'b0100);
        chk("one_err", o_err, 0);
        chk("one_hash", o_hash, ABC_HASH);
        chk("one_gnt_off", o_gnt, 0);
        chk("one_start_off", o_core_start, 0);
        i_req = '0;
        tick();
        chk("one_done_pulse", o_done, 0);
        chk("one_hash_hold", o_hash, ABC_HASH);
        chk("one_idle_busy", o_busy, 0);

        // All four requesting from reset: strict rotation 0,1,2,3,0.
        usr_reset_n = 1'b0;
        core_lat    = 5;
        i_req       = 4'b1111;
        tick();
        usr_reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(n);
            chk("rr_gap", n, (k == 0) ? 1 : 2);
            exp_oh = 4'b0001 << (k % 4);
            chk("rr_gnt", o_gnt, exp_oh);
            wait_done(n);
            chk("rr_done", o_done, exp_oh);
        end
        i_req = '0;
        tick();

        // Core never answers: watchdog abort, then requester 3 served normally.
        core_lat = 0;
        i_req    = 4'b1010;
        wait_gnt(n);
        chk("to_gnt", o_gnt, 4'b0010);
        wait_done(n);
        chk("to_lat", n, TO);
        chk("to_done", o_done, 4'b0010);
        chk("to_err", o_err, 1);
        chk("to_hash", o_hash, 0);
        core_lat = 5;
        i_req    = 4'b1000;
        tick();
        chk("to_err_pulse", o_err, 0);
        wait_gnt(n);
        chk("to_next_gap", n, 1);
        chk("to_next_gnt", o_gnt, 4'b1000);
        wait_done(n);
        chk("to_next_err", o_err, 0);
        chk("to_next_hash", o_hash, hash_of(M3));
        i_req = '0;
        tick();

        // Valid arrives exactly on the last watchdog cycle.
        core_lat = 100;
        i_req    = 4'b0001;
        wait_gnt(n);
        chk("co_gnt", o_gnt, 4'b0001);
        wait_done(n);
        chk("co_lat", n, TO);
        chk("co_err", o_err, 0);
        chk("co_hash", o_hash, hash_of(M0));
        i_req = '0;
        tick();

        // Requester 1 drops its request and changes its message mid-job.
        core_lat = 20;
        i_req    = 4'b0110;
        wait_gnt(n);
        chk("drop_gnt", o_gnt, 4'b0010);
        chk("drop_msg", o_core_msg, M1);
        repeat (3) tick();
        i_req = 4'b0100;
        i_msg[1*MW +: MW] = 24'h0BAD00;
        repeat (2) tick();
        chk("drop_msg_held", o_core_msg, M1);
        wait_done(n);
        chk("drop_done", o_done, 4'b0010);
        chk("drop_hash", o_hash, hash_of(M1));
        wait_gnt(n);
        chk("drop_next_gap", n, 2);
        chk("drop_next_gnt", o_gnt, 4'b0100);
        chk("drop_next_msg", o_core_msg, M2);
        wait_done(n);
        i_req = '0;
        tick();

        // Reset pulse in the middle of a job.
        core_lat = 0;
        i_req    = 4'b1001;
        wait_gnt(n);
        chk("mr_gnt", o_gnt, 4'b1000);
        repeat (29) tick();
        usr_reset_n = 1'b0;
        tick();
        chk("mr_start", o_core_start, 0);
        chk("mr_gnt_off", o_gnt, 0);
        chk("mr_busy", o_busy, 0);
        chk("mr_done", o_done, 0);
        chk("mr_msg", o_core_msg, 0);
        usr_reset_n = 1'b1;
        core_lat    = 5;
        wait_gnt(n);
        chk("mr_regnt_gap", n, 1);
        chk("mr_regnt", o_gnt, 4'b0001);
        wait_done(n);
        chk("mr_redone", o_done, 4'b0001);
        i_req = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
